// File: rtl/hxm_road_reader_pkg.sv
// Shared widths, FSM state type and the hit-count rule for the hxmpp read-side client.
package hxm_road_reader_pkg;

  localparam int SSIDBITS    = 8;
  localparam int HITINFOBITS = 16;
  localparam int MAXHITNBITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Beats to emit for a response; a miss always yields zero regardless of nHits.
  function automatic int hit_count(input logic hit_this_event, input int n_hits, input int max_hits);
    if (!hit_this_event) return 0;
    return (n_hits > max_hits) ? max_hits : n_hits;
  endfunction

endpackage

// File: rtl/hxm_road_reader_if.sv
// Request stream, hxmpp read port, output beat stream and error flags of the road reader.
interface hxm_road_reader_if
  import hxm_road_reader_pkg::*;
#(
  parameter int MAXHITS = 4
);
  logic                           req_valid;
  logic                           req_ready;
  logic [SSIDBITS-1:0]            req_ssid;
  logic                           read;
  logic [SSIDBITS-1:0]            readSSID;
  logic                           readFinished;
  logic [SSIDBITS-1:0]            SSID_read;
  logic                           hitThisEvent;
  logic [MAXHITNBITS-1:0]         nHits;
  logic [HITINFOBITS*MAXHITS-1:0] hitInfo_read;
  logic                           out_valid;
  logic                           out_ready;
  logic [SSIDBITS-1:0]            out_ssid;
  logic [HITINFOBITS-1:0]         out_hit;
  logic                           out_last;
  logic                           out_empty;
  logic                           err_timeout;
  logic                           err_mismatch;
  logic                           err_overflow;
  logic                           err_clear;

  // The reader masters the hxmpp read port and sources the output stream.
  modport master (
    input  req_valid, req_ssid, readFinished, SSID_read, hitThisEvent, nHits, hitInfo_read,
           out_ready, err_clear,
    output req_ready, read, readSSID, out_valid, out_ssid, out_hit, out_last, out_empty,
           err_timeout, err_mismatch, err_overflow
  );

  modport slave (
    output req_valid, req_ssid, readFinished, SSID_read, hitThisEvent, nHits, hitInfo_read,
           out_ready, err_clear,
    input  req_ready, read, readSSID, out_valid, out_ssid, out_hit, out_last, out_empty,
           err_timeout, err_mismatch, err_overflow
  );
endinterface

// File: rtl/hxm_hit_slot_mux.sv
// Combinational selector of one hit word from the packed hit bus; out-of-range selects give 0.
module hxm_hit_slot_mux #(
  parameter int HITINFOBITS = 16,
  parameter int MAXHITS     = 4,
  parameter int SELW        = 3
) (
  input  logic [HITINFOBITS*MAXHITS-1:0] hits,
  input  logic [SELW-1:0]                sel,
  output logic [HITINFOBITS-1:0]         hit
);

  always_comb begin
    hit = '0;
    for (int k = 0; k < MAXHITS; k++) begin
      if (int'(sel) == k) hit = hits[HITINFOBITS*k +: HITINFOBITS];
    end
  end

endmodule

// File: rtl/hxm_road_reader.sv
// Read-side client of hxmpp: one read per requested SSID, response unpacked into one beat per hit.
module hxm_road_reader
  import hxm_road_reader_pkg::*;
#(
  parameter int MAXHITS = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset_n,
  hxm_road_reader_if.master bus
);

  localparam int CNTW = $clog2(MAXHITS + 1);
  localparam int TMRW = $clog2(TIMEOUT);

  state_t                         state, state_next;
  logic [SSIDBITS-1:0]            ssid_q;
  logic [HITINFOBITS*MAXHITS-1:0] hits_q;
  logic [CNTW-1:0]                count_q, idx_q, resp_count;
  logic [TMRW-1:0]                timer_q;
  logic [HITINFOBITS-1:0]         slot_hit;
  logic                           got_resp, timed_out, is_empty, is_last, beat_done;

  assign got_resp   = (state == WAIT) && bus.readFinished;
  assign timed_out  = (state == WAIT) && !bus.readFinished && (timer_q == TMRW'(TIMEOUT - 1));
  assign is_empty   = (count_q == '0);
  assign is_last    = is_empty || (idx_q == count_q - 1'b1);
  assign beat_done  = (state == EMIT) && bus.out_ready;
  assign resp_count = CNTW'(hit_count(bus.hitThisEvent, int'(bus.nHits), MAXHITS));

  hxm_hit_slot_mux #(
    .HITINFOBITS(HITINFOBITS),
    .MAXHITS    (MAXHITS),
    .SELW       (CNTW)
  ) u_slot_mux (
    .hits(hits_q),
    .sel (idx_q),
    .hit (slot_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Output fields are forced to 0 outside their state so nothing stale leaks after a reset or timeout.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.read      = 1'b0;
    bus.readSSID  = '0;
    bus.out_valid = 1'b0;
    bus.out_ssid  = '0;
    bus.out_hit   = '0;
    bus.out_last  = 1'b0;
    bus.out_empty = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = reset_n;
        if (bus.req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        bus.read     = 1'b1;
        bus.readSSID = ssid_q;
        state_next   = WAIT;
      end
      WAIT: begin
        if (got_resp || timed_out) state_next = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_ssid  = ssid_q;
        bus.out_hit   = is_empty ? '0 : slot_hit;
        bus.out_last  = is_last;
        bus.out_empty = is_empty;
        if (bus.out_ready && is_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ssid_q  <= '0;
      hits_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) ssid_q <= bus.req_ssid;
        ISSUE: timer_q <= '0;
        WAIT: begin
          timer_q <= timer_q + 1'b1;
          idx_q   <= '0;
          if (got_resp) begin
            hits_q  <= bus.hitInfo_read;
            count_q <= resp_count;
          end else if (timed_out) begin
            hits_q  <= '0;
            count_q <= '0;
          end
        end
        EMIT: if (beat_done) idx_q <= is_last ? '0 : idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // A new error event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.err_timeout  <= 1'b0;
      bus.err_mismatch <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      bus.err_timeout  <= timed_out | (bus.err_timeout & ~bus.err_clear);
      bus.err_mismatch <= (got_resp && (bus.SSID_read != ssid_q)) |
                          (bus.err_mismatch & ~bus.err_clear);
      bus.err_overflow <= (got_resp && (int'(bus.nHits) > MAXHITS)) |
                          (bus.err_overflow & ~bus.err_clear);
    end
  end

endmodule

// File: doc/hxm_road_reader.md
# hxm_road_reader

Read-side client of `hxmpp`. Accepts a stream of SSIDs to look up, issues one `read` pulse per SSID, waits for `readFinished`, and unpacks the returned hit words into a valid/ready stream with one beat per hit. Sits between the road/SSID request source and downstream track fitting. It is the consumer counterpart of the `hxmpp` read port.

## Interface
Parameters:
- `SSIDBITS`, from `MyParameters.vh`: SSID width.
- `HITINFOBITS`, from `MyParameters.vh`: width of one hit word.
- `MAXHITNBITS`, from `MyParameters.vh`: width of `nHits`.
- `MAXHITS`, 4: hit slots packed in `hitInfo_read`.
- `TIMEOUT`, 64: cycles to wait for `readFinished`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — SSID request valid.
- `req_ready`  out  1  — request accepted when high with `req_valid`.
- `req_ssid`  in  SSIDBITS  — SSID to look up.
- `read`  out  1  — one-cycle read strobe to `hxmpp`.
- `readSSID`  out  SSIDBITS  — SSID presented with `read`.
- `readFinished`  in  1  — response strobe from `hxmpp`.
- `SSID_read`  in  SSIDBITS  — echoed SSID.
- `hitThisEvent`  in  1  — SSID had hits this event.
- `nHits`  in  MAXHITNBITS  — hit count.
- `hitInfo_read`  in  HITINFOBITS*MAXHITS  — packed hits; slot k is at `[HITINFOBITS*(k+1)-1 : HITINFOBITS*k]`.
- `out_valid`  out  1 / `out_ready`  in  1  — output handshake.
- `out_ssid`  out  SSIDBITS, `out_hit`  out  HITINFOBITS  — output beat.
- `out_last`  out  1  — final beat for this SSID.
- `out_empty`  out  1  — beat carries no hit (no hits, or timeout).
- `err_timeout`, `err_mismatch`, `err_overflow`  out  1 each  — sticky error flags.
- `err_clear`  in  1  — synchronous clear of the sticky flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_ssid` and go to ISSUE.
- ISSUE:
  - `read`=1 and `readSSID`=latched SSID for exactly one cycle.
  - Clear the timer and go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On `readFinished`, latch `SSID_read`, `hitThisEvent`, `nHits` and `hitInfo_read`, then go to EMIT.
  - Count rule: count = 0 if `hitThisEvent`=0; otherwise min(`nHits`, MAXHITS).
  - If `nHits` > MAXHITS, set `err_overflow` and truncate to MAXHITS.
  - If `SSID_read` ≠ latched SSID, set `err_mismatch` and still emit, using the latched request SSID on `out_ssid`.
  - If the timer reaches TIMEOUT-1 with no `readFinished`, set `err_timeout` and go to EMIT with count = 0.
- EMIT:
  - If count = 0: emit one beat with `out_empty`=1, `out_last`=1, `out_hit`=0.
  - Otherwise emit beats k = 0..count-1, with `out_hit` = slot k and `out_last`=1 on k = count-1.
  - Index k advances only on `out_valid` && `out_ready`.
  - After the last beat is accepted, go to IDLE.
- `readFinished` outside WAIT is ignored; it does not set any flag.
- `err_clear` clears all three flags. If an error event occurs in the same cycle, the set wins.

## Timing
- Reset (`reset_n`=0, any state): FSM goes to IDLE; all outputs 0 (`req_ready`=0 while `reset_n` is low, 1 from the first cycle after release); timer, index and flags are cleared. A reset mid-transaction drops it, and no partial beats remain.
- Request accepted at edge T → `read` high in cycle T+1.
- `readFinished` sampled at edge R → `out_valid` high from cycle R+1.
- With `out_ready` held at 1, a response with count n occupies n beats in consecutive cycles. The next request can be accepted in the cycle after the last beat.
- Minimum per-SSID overhead: 3 cycles plus the `hxmpp` latency.
- While `out_valid`=1 and `out_ready`=0, `out_ssid`, `out_hit`, `out_last` and `out_empty` are held stable.
- Timeout: with no response, `out_valid` rises TIMEOUT+1 cycles after `read`.
- Only one read is outstanding at a time.

## Structure
- `MyParameters.vh` supplies SSIDBITS, HITINFOBITS and MAXHITNBITS.
- The FSM state encoding is a local parameter in this block.
- One natural sub-module: `hxm_hit_slot_mux`, a combinational selector of slot k from the latched packed bus, instantiated once.

## Test plan
- SSID 0x88 with `hitThisEvent`=1, `nHits`=3, slots 11/22/33; `out_ready`=1 → three beats with `out_hit` 11, 22, 33 in consecutive cycles; `out_last` on the third beat only; `read` pulses exactly once.
- SSID 0x4C with `hitThisEvent`=0 → one beat with `out_empty`=1, `out_last`=1, `out_hit`=0; no error flags set.
- `nHits`=6 with MAXHITS=4 → four beats, `err_overflow`=1; `err_clear` pulse → flag returns to 0.
- No `readFinished` (TIMEOUT=64) → `out_valid` rises 65 cycles after `read`, one empty/last beat, `err_timeout`=1; a late `readFinished` in IDLE is ignored.
- `out_ready` toggling 1,0,0,1 during a 2-hit response → data held stable while stalled; both beats delivered in order; back-to-back requests produce no lost or duplicated `read`.
- `reset_n` pulled low in WAIT → all outputs 0 at once; after release, a new request completes normally and no stale beats appear.
